// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, a pending
// scoreboard for issue, and a sequenced hardware clear after reset or on request.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 1,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    output logic                 ready,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_pending,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr
);
    typedef enum logic {CLEAR, READY} state_t;

    state_t                     state, state_nxt;
    logic [AW-1:0]              clr_idx;
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           pending;

    assign ready = (state == READY);

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (clr_idx == AW'(NREGS-1)) state_nxt = READY;
            READY: if (clear_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
            else                clr_idx <= '0;
        end
    end

    // Later ports are assigned last, so the highest-index port wins on conflicts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else begin
                for (int j = 0; j < NWR; j++)
                    if (wr_en[j] && !((ZERO_R0 != 0) && wr_addr[j*AW +: AW] == '0))
                        regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Alloc is applied after write clears so a same-cycle new producer stays pending.
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR || clear_req) begin
            pending <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j]) pending[wr_addr[j*AW +: AW]] <= 1'b0;
            if (alloc_en && !((ZERO_R0 != 0) && alloc_addr == '0))
                pending[alloc_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            p;

        assign a = rd_addr[i*AW +: AW];

        always_comb begin
            d = regs[a];
            p = pending[a];
            if (BYPASS != 0)
                for (int j = 0; j < NWR; j++)
                    if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                        d = wr_data[j*XLEN +: XLEN];
                        p = 1'b0;
                    end
            if ((ZERO_R0 != 0) && a == '0) begin
                d = '0;
                p = 1'b0;
            end
            if (!ready) begin
                d = '0;
                p = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = d;
        assign rd_pending[i]           = p;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one bypassing and one non-bypassing file driven in lockstep.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst, clear_req, alloc_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  alloc_addr;
    logic        rdy_a, rdy_b;
    logic [63:0] rdd_a, rdd_b;
    logic [1:0]  pnd_a, pnd_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.NWR(2), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy_a),
        .rd_addr(rd_addr), .rd_data(rdd_a), .rd_pending(pnd_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    regfile_mp #(.NWR(2), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy_b),
        .rd_addr(rd_addr), .rd_data(rdd_b), .rd_pending(pnd_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; alloc_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
    endtask

    initial begin
        rst = 1'b1; idle(); rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
        tick(); tick();
        chk("rst_ready_a", 32'(rdy_a), 32'd0);
        chk("rst_ready_b", 32'(rdy_b), 32'd0);
        rst = 1'b0;

        // ready rises exactly on the 32nd edge after reset release
        for (int k = 1; k <= 32; k++) begin
            rd_addr = {5'd0, 5'(k)};
            tick();
            chk($sformatf("init_ready_%0d", k), 32'(rdy_a), 32'(k == 32));
            chk($sformatf("init_rd_%0d", k), rdd_a[31:0], 32'd0);
        end
        chk("init_ready_b", 32'(rdy_b), 32'd1);
        for (int r = 1; r < 32; r++) begin
            rd_addr = {5'(r), 5'(r)};
            #1;
            chk($sformatf("clr_r%0d", r), rdd_a[63:32], 32'd0);
        end

        // same-cycle bypass vs. next-cycle visibility
        rd_addr = {5'd0, 5'd5};
        wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        #1;
        chk("byp_a", rdd_a[31:0], 32'hDEADBEEF);
        chk("nobyp_b", rdd_b[31:0], 32'h0);
        tick(); idle(); #1;
        chk("wr5_a", rdd_a[31:0], 32'hDEADBEEF);
        chk("wr5_b", rdd_b[31:0], 32'hDEADBEEF);

        rd_addr = {5'd0, 5'd0};
        wr(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0);
        #1;
        chk("r0_byp_a", rdd_a[31:0], 32'h0);
        tick(); idle(); #1;
        chk("r0_a", rdd_a[31:0], 32'h0);
        chk("r0_b", rdd_b[31:0], 32'h0);

        // both ports write r7; port 1 wins
        rd_addr = {5'd7, 5'd0};
        wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        #1;
        chk("dual_byp_a", rdd_a[63:32], 32'h22);
        chk("dual_old_b", rdd_b[63:32], 32'h0);
        tick(); idle(); #1;
        chk("dual_a", rdd_a[63:32], 32'h22);
        chk("dual_b", rdd_b[63:32], 32'h22);

        // scoreboard
        rd_addr = {5'd0, 5'd9};
        alloc_en = 1'b1; alloc_addr = 5'd9;
        #1;
        chk("alloc_same_cyc", 32'(pnd_a[0]), 32'd0);
        tick(); idle(); #1;
        chk("alloc_pend_a", 32'(pnd_a[0]), 32'd1);
        chk("alloc_pend_b", 32'(pnd_b[0]), 32'd1);
        wr(2'b01, 5'd9, 32'h55, 5'd0, 32'h0);
        #1;
        chk("wb_mask_a", 32'(pnd_a[0]), 32'd0);
        chk("wb_data_a", rdd_a[31:0], 32'h55);
        chk("wb_nomask_b", 32'(pnd_b[0]), 32'd1);
        chk("wb_old_b", rdd_b[31:0], 32'h0);
        tick(); idle(); #1;
        chk("wb_clr_a", 32'(pnd_a[0]), 32'd0);
        chk("wb_clr_b", 32'(pnd_b[0]), 32'd0);
        alloc_en = 1'b1; alloc_addr = 5'd9;
        wr(2'b01, 5'd9, 32'h66, 5'd0, 32'h0);
        #1;
        chk("aw_mask_a", 32'(pnd_a[0]), 32'd0);
        tick(); idle(); #1;
        chk("aw_pend_a", 32'(pnd_a[0]), 32'd1);
        chk("aw_pend_b", 32'(pnd_b[0]), 32'd1);
        chk("aw_data_b", rdd_b[31:0], 32'h66);
        alloc_en = 1'b1; alloc_addr = 5'd0;
        rd_addr = {5'd0, 5'd9};
        tick(); idle(); #1;
        chk("alloc_r0", 32'(pnd_a[1]), 32'd0);

        // mid-operation clear
        rd_addr = {5'd4, 5'd3};
        wr(2'b01, 5'd3, 32'hA5, 5'd0, 32'h0);
        alloc_en = 1'b1; alloc_addr = 5'd4;
        tick(); idle(); #1;
        chk("pre_clr_r3", rdd_a[31:0], 32'hA5);
        chk("pre_clr_p4", 32'(pnd_a[1]), 32'd1);
        clear_req = 1'b1;
        #1;
        chk("clr_req_ready", 32'(rdy_a), 32'd1);
        tick(); idle(); #1;
        chk("clr_drop_a", 32'(rdy_a), 32'd0);
        chk("clr_drop_b", 32'(rdy_b), 32'd0);
        chk("clr_rd_zero", rdd_b[31:0], 32'h0);
        for (int k = 1; k <= 32; k++) begin
            if (k <= 5) begin
                wr(2'b01, 5'd3, 32'h77, 5'd0, 32'h0);
                alloc_en = 1'b1; alloc_addr = 5'd4; clear_req = 1'b1;
            end else begin
                idle();
            end
            tick();
            chk($sformatf("clr_ready_%0d", k), 32'(rdy_a), 32'(k == 32));
        end
        idle(); #1;
        chk("post_clr_r3", rdd_a[31:0], 32'h0);
        chk("post_clr_p4_a", 32'(pnd_a[1]), 32'd0);
        chk("post_clr_p4_b", 32'(pnd_b[1]), 32'd0);
        chk("post_clr_r4", rdd_b[63:32], 32'h0);
        rd_addr = {5'd9, 5'd7};
        #1;
        chk("post_clr_r7", rdd_a[31:0], 32'h0);
        chk("post_clr_p9", 32'(pnd_a[1]), 32'd0);

        // rst in the middle of a clear restarts the sequence
        wr(2'b01, 5'd12, 32'hBEEF, 5'd0, 32'h0);
        tick(); idle();
        clear_req = 1'b1;
        tick(); idle();
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("rst_clr_ready_%0d", k), 32'(rdy_b), 32'(k == 32));
        end
        rd_addr = {5'd12, 5'd12};
        #1;
        chk("rst_clr_r12", rdd_a[31:0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the successor to the current 2R/1W file. It adds configurable width, depth and port counts, and same-cycle write-to-read bypass. It also adds a per-register pending scoreboard for the issue stage and a sequenced hardware clear, which replaces the simulation-only initial block. It sits between decode/issue (reads, allocations) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports
NWR, 1, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding
ZERO_R0, 1, 1 = register 0 hardwired to zero, never written, never pending
(localparam AW = $clog2(NREGS))

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
clear_req  input  1  pulse; requests a full re-clear of the file
ready  output  1  1 = file initialised and accepting writes/allocs
rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN], combinational
rd_pending  output  NRD  1 = register at rd_addr[i] awaits a writeback
wr_en  input  NWR  write enables
wr_addr  input  NWR*AW  write addresses
wr_data  input  NWR*XLEN  write data
alloc_en  input  1  marks alloc_addr pending (destination issued)
alloc_addr  input  AW  register to mark pending

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- FSM with two states, CLEAR and READY.
  - rst=1 at an edge: state<=CLEAR, clr_idx<=0, all pending bits<=0. Remains so while rst is held.
  - In CLEAR, each edge: regs[clr_idx]<=0, clr_idx<=clr_idx+1. The edge that clears index NREGS-1 moves to READY.
  - ready is 1 only in READY. It rises exactly NREGS edges after the first edge with rst=0.
  - READY with clear_req=1 at an edge: state<=CLEAR, clr_idx<=0, all pending<=0. clear_req is ignored while in CLEAR.
  - rst has priority over every other input.
- While ready=0:
  - wr_en, alloc_en and clear_req have no effect.
  - rd_data reads all zero.
  - rd_pending is all zero.
- Write (ready=1):
  - At the edge, regs[wr_addr[j]]<=wr_data[j] for each j with wr_en[j]=1.
  - When several ports write the same address, the highest-index port wins.
  - Address 0 is dropped when ZERO_R0=1.
- Read (combinational):
  - Address 0 returns 0 when ZERO_R0=1.
  - Otherwise, if BYPASS=1 and some enabled write port targets rd_addr[i] (and ready=1), return that port's wr_data (highest index wins).
  - Otherwise return regs[rd_addr[i]].
  - With BYPASS=0, a written value is first visible in the cycle after the write edge.
- Scoreboard (ready=1):
  - alloc_en sets pending[alloc_addr] at the edge. Address 0 is ignored when ZERO_R0=1.
  - An enabled write clears pending[wr_addr[j]] at the edge.
  - Alloc and write to the same address in the same cycle: alloc wins, and the bit ends up set (new producer).
- rd_pending[i]:
  - Equals pending[rd_addr[i]].
  - When BYPASS=1 it is forced 0 if an enabled write in the same cycle targets rd_addr[i], because the data is forwarded.
  - With BYPASS=0, a write does not mask rd_pending in its own cycle.
- Out-of-range addresses cannot occur (NREGS is a power of two).
- No X on any output after the first reset edge.

Test Plan:
- Reset and clear timing (NREGS=32): rst high 2 cycles, then low. ready=0 for exactly 32 edges, then 1. Reads of r1..r31 return 0 throughout and after.
- Write/read with BYPASS=1 (NWR=1, NRD=2):
  - wr r5=0xDEADBEEF while rd_addr0=5: rd_data0=0xDEADBEEF in the same cycle.
  - Write r0=0x1234, then read r0: returns 0.
- Multi-write conflict (NWR=2): both ports write r7 in one cycle, port0=0x11 and port1=0x22. Next cycle r7 reads 0x22. With BYPASS=0, r7 reads its old value in the write cycle.
- Scoreboard:
  - alloc r9: rd_pending for r9=1 from the next cycle.
  - Write r9=0x55: rd_pending=0 in that same cycle (BYPASS=1) with data 0x55.
  - Simultaneous alloc r9 and write r9: pending stays 1.
- Mid-operation clear:
  - Write r3=0xA5, alloc r4, pulse clear_req. ready drops next cycle.
  - Writes and allocs during CLEAR are ignored.
  - After 32 edges, ready=1, r3 reads 0 and r4 is not pending.
- rst asserted during CLEAR at clr_idx=10: clearing restarts from 0, and ready rises 32 edges after rst deasserts.
